pw_attempt_ctrl: RTL and testbench
==================================

PW_ATTEMPT_CTRL -- requirements
Module: pw_attempt_ctrl

Interface
REQ-001 Parameter CLK_HZ, 12000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 115200, serial bit rate.
REQ-003 Parameter BAUD_P, CLK_HZ/BAUD (=104), clock cycles per serial bit.
REQ-004 Parameter RESP_WAIT, 2000, cycles the unlock indication is watched after each attempt.
REQ-005 Parameter GAP_BITS, 10, idle-high bit times between attempts.
REQ-006 clk  in  1  system clock; the block has exactly one clock domain.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  single-cycle pulse that begins a search from base_pw.
REQ-009 abort  in  1  single-cycle pulse that terminates the search.
REQ-010 base_pw  in  64  first candidate password, sampled on an accepted start.
REQ-011 max_attempts  in  16  attempt limit, sampled on an accepted start; 0 means unlimited.
REQ-012 led_g_n  in  1  asynchronous unlock indication from the target chip, active low.
REQ-013 tx  out  1  serial line to the target chip rx, idle high.
REQ-014 busy  out  1  high in SEND, WAIT_RESP and GAP.
REQ-015 found  out  1  high while in FOUND.
REQ-016 exhausted  out  1  high while in EXHAUSTED.
REQ-017 candidate  out  64  current candidate; holds the unlocking password while in FOUND.
REQ-018 attempts  out  16  completed attempts, including the current one once its stop bit ends.

Function
REQ-019 The FSM SHALL have the states IDLE, SEND, WAIT_RESP, GAP, FOUND and EXHAUSTED.
REQ-020 start in IDLE, FOUND or EXHAUSTED SHALL load candidate<=base_pw, clear attempts, found and exhausted, and enter SEND; start in SEND, WAIT_RESP or GAP SHALL be ignored.
REQ-021 SEND SHALL transmit 8 frames, byte k = candidate[8k+7:8k], k=0 first; each frame is one start bit (0), 8 data bits LSB first, then one stop bit (1).
REQ-022 Each bit SHALL be held on registered tx for exactly BAUD_P cycles; the first start bit SHALL appear on the cycle after start is accepted, with no idle bit between frames.
REQ-023 After the last stop bit, attempts SHALL increment (saturating at 16'hFFFF) and the FSM SHALL enter WAIT_RESP for RESP_WAIT cycles.
REQ-024 led_g_n SHALL pass through a 2-flop synchronizer; a synchronized low in WAIT_RESP SHALL enter FOUND on the next cycle, with candidate unchanged.
REQ-025 A synchronized led_g_n low outside WAIT_RESP SHALL be ignored.
REQ-026 If WAIT_RESP expires without unlock: when max_attempts!=0 and attempts==max_attempts, the FSM SHALL enter EXHAUSTED; otherwise candidate<=candidate+1 (mod 2^64, so 64'hFFFF_FFFF_FFFF_FFFF wraps to 0) and the FSM SHALL enter GAP.
REQ-027 GAP SHALL hold tx=1 for GAP_BITS*BAUD_P cycles, then return to SEND.
REQ-028 abort in any state SHALL force tx=1 on the next cycle and enter IDLE with candidate and attempts retained; a partial frame is abandoned.
REQ-029 If abort and start occur in the same cycle, abort SHALL win.
REQ-030 tx SHALL be 1 in every state except SEND.

Reset
REQ-031 While reset_n=0: state=IDLE, tx=1, busy=0, found=0, exhausted=0, candidate=0, attempts=0, all counters and synchronizer flops 0 except the synchronizer, which resets to 1.
REQ-032 Assertion of reset_n mid-frame SHALL drive tx high immediately (asynchronously).

Structure
REQ-033 The state enum, BAUD_P computation and frame constants (10 bits per frame, 8 frames per attempt) SHALL reside in a shared package pw_attempt_pkg.
REQ-034 The bit/frame serializer SHALL be one sub-module, uart_frame_tx (byte in, valid/ready handshake, tx out, baud counter internal); the FSM in pw_attempt_ctrl SHALL sequence it.

Verification
REQ-035 base_pw=64'h293a216b33713234, max_attempts=1, start; decode tx -> bytes 34 32 71 33 6b 21 3a 29, then exhausted=1 and attempts=1.
REQ-036 Target model unlocks on 64'h0000_0000_0000_0005; base_pw=3, max_attempts=0 -> found=1, candidate=5, attempts=3.
REQ-037 base_pw=64'hFFFF_FFFF_FFFF_FFFF, max_attempts=2 -> second attempt transmits 00 x8, then exhausted=1.
REQ-038 abort during bit 4 of frame 2 -> tx=1 the next cycle, state IDLE, busy=0; a subsequent start restarts from base_pw.
REQ-039 reset_n low mid-frame, then released -> tx=1 throughout reset, all outputs at reset values; start pulse during SEND -> no effect.
REQ-040 Measure every bit width = 104 cycles and inter-attempt gap = 1040 cycles (at BAUD_P=104, GAP_BITS=10).

Source files
------------

// File: rtl/pw_attempt_pkg.sv
// Shared types and constants for the password-attempt controller and its UART serializer.
package pw_attempt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_GAP       = 3'd3,
        ST_FOUND     = 3'd4,
        ST_EXHAUSTED = 3'd5
    } state_e;

    localparam int unsigned PW_W               = 64;
    localparam int unsigned ATT_W              = 16;
    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned FRAME_BITS         = 10;
    localparam int unsigned FRAMES_PER_ATTEMPT = 8;
    localparam int unsigned FIDX_W             = $clog2(FRAMES_PER_ATTEMPT);

    function automatic int unsigned calc_baud_p(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Byte k of a password, byte 0 being the first one on the wire.
    function automatic logic [DATA_BITS-1:0] select_byte(input logic [PW_W-1:0] pw,
                                                         input logic [FIDX_W-1:0] k);
        return pw[{k, 3'b000} +: DATA_BITS];
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// 8N1 frame serializer: accepts a byte on valid&ready and shifts it out LSB first.
// ready_c rises in the last stop-bit cycle so back-to-back frames have no idle bit.
module uart_frame_tx
    import pw_attempt_pkg::*;
#(
    parameter int unsigned BAUD_P = 104
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear_i,
    input  logic                 valid_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 ready_c,
    output logic                 last_c,
    output logic                 tx_o
);

    localparam int unsigned CNT_W = (BAUD_P > 1) ? $clog2(BAUD_P) : 1;
    localparam int unsigned IDX_W = $clog2(FRAME_BITS);

    logic                 busy_q,  busy_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q,    tx_d;
    logic                 bit_end_c;

    assign bit_end_c = (cnt_q == CNT_W'(BAUD_P - 1));
    assign last_c    = busy_q && bit_end_c && (idx_q == IDX_W'(FRAME_BITS - 1));
    assign ready_c   = !busy_q || last_c;
    assign tx_o      = tx_q;

    // Shift register refills with ones so the stop bit falls out after the data bits.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (clear_i) begin
            busy_d = 1'b0;
            tx_d   = 1'b1;
            cnt_d  = '0;
            idx_d  = '0;
        end else if (valid_i && ready_c) begin
            busy_d  = 1'b1;
            tx_d    = 1'b0;
            shift_d = data_i;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (busy_q) begin
            if (bit_end_c) begin
                cnt_d = '0;
                if (last_c) begin
                    busy_d = 1'b0;
                    tx_d   = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[DATA_BITS-1:1]};
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/pw_attempt_ctrl.sv
// Sequential password search: serializes each 64-bit candidate to the target chip,
// watches its unlock LED, and steps to the next candidate until found, exhausted or aborted.
module pw_attempt_ctrl
    import pw_attempt_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 12000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned BAUD_P    = calc_baud_p(CLK_HZ, BAUD),
    parameter int unsigned RESP_WAIT = 2000,
    parameter int unsigned GAP_BITS  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PW_W-1:0]  base_pw,
    input  logic [ATT_W-1:0] max_attempts,
    input  logic             led_g_n,
    output logic             tx,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic [PW_W-1:0]  candidate,
    output logic [ATT_W-1:0] attempts
);

    localparam int unsigned GAP_LEN = GAP_BITS * BAUD_P;
    localparam int unsigned TMR_MAX = (RESP_WAIT > GAP_LEN) ? RESP_WAIT : GAP_LEN;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_e              state_q, state_d;
    logic [FIDX_W-1:0]   frame_q, frame_d;
    logic [TMR_W-1:0]    tmr_q,   tmr_d;
    logic [PW_W-1:0]     cand_q,  cand_d;
    logic [ATT_W-1:0]    att_q,   att_d;
    logic [ATT_W-1:0]    max_q,   max_d;
    logic                busy_q, found_q, exh_q;
    logic                led_s1_q, led_s2_q;

    logic                unlock_c;
    logic                utx_valid_c, utx_clear_c, utx_ready_c, utx_last_c;
    logic [DATA_BITS-1:0] utx_byte_c;

    assign unlock_c  = !led_s2_q;
    assign busy      = busy_q;
    assign found     = found_q;
    assign exhausted = exh_q;
    assign candidate = cand_q;
    assign attempts  = att_q;

    uart_frame_tx #(
        .BAUD_P (BAUD_P)
    ) u_frame_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (utx_clear_c),
        .valid_i (utx_valid_c),
        .data_i  (utx_byte_c),
        .ready_c (utx_ready_c),
        .last_c  (utx_last_c),
        .tx_o    (tx)
    );

    // Next-state logic; the serializer is fed in the same cycle a frame must begin.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        tmr_d       = tmr_q;
        cand_d      = cand_q;
        att_d       = att_q;
        max_d       = max_q;
        utx_valid_c = 1'b0;
        utx_clear_c = 1'b0;
        utx_byte_c  = select_byte(cand_q, frame_q);
        if (abort) begin
            state_d     = ST_IDLE;
            utx_clear_c = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                    if (start) begin
                        cand_d      = base_pw;
                        att_d       = '0;
                        max_d       = max_attempts;
                        frame_d     = '0;
                        state_d     = ST_SEND;
                        utx_valid_c = 1'b1;
                        utx_byte_c  = select_byte(base_pw, '0);
                    end
                end
                ST_SEND: begin
                    if (utx_last_c) begin
                        if (frame_q == FIDX_W'(FRAMES_PER_ATTEMPT - 1)) begin
                            att_d   = (att_q == '1) ? att_q : att_q + ATT_W'(1);
                            tmr_d   = '0;
                            state_d = ST_WAIT_RESP;
                        end else begin
                            frame_d     = frame_q + FIDX_W'(1);
                            utx_valid_c = utx_ready_c;
                            utx_byte_c  = select_byte(cand_q, frame_q + FIDX_W'(1));
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (unlock_c) begin
                        state_d = ST_FOUND;
                    end else if (tmr_q == TMR_W'(RESP_WAIT - 1)) begin
                        if ((max_q != '0) && (att_q == max_q)) begin
                            state_d = ST_EXHAUSTED;
                        end else begin
                            cand_d  = cand_q + PW_W'(1);
                            tmr_d   = '0;
                            state_d = ST_GAP;
                        end
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (tmr_q == TMR_W'(GAP_LEN - 1)) begin
                        frame_d     = '0;
                        state_d     = ST_SEND;
                        utx_valid_c = 1'b1;
                        utx_byte_c  = select_byte(cand_q, '0);
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            frame_q  <= '0;
            tmr_q    <= '0;
            cand_q   <= '0;
            att_q    <= '0;
            max_q    <= '0;
            busy_q   <= 1'b0;
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            led_s1_q <= 1'b1;
            led_s2_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            tmr_q    <= tmr_d;
            cand_q   <= cand_d;
            att_q    <= att_d;
            max_q    <= max_d;
            busy_q   <= (state_d == ST_SEND) || (state_d == ST_WAIT_RESP) || (state_d == ST_GAP);
            found_q  <= (state_d == ST_FOUND);
            exh_q    <= (state_d == ST_EXHAUSTED);
            led_s1_q <= led_g_n;
            led_s2_q <= led_s1_q;
        end
    end

endmodule

// File: tb/tb_pw_attempt_ctrl.sv
// Directed bench for pw_attempt_ctrl: UART decoder plus a target-chip model that
// pulls the unlock LED low when the last 8 received bytes form the target password.
module tb_pw_attempt_ctrl;

    localparam int BP = 104;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] base_pw = '0;
    logic [15:0] max_attempts = '0;
    logic        led_g_n;
    logic        tx, busy, found, exhausted;
    logic [63:0] candidate;
    logic [15:0] attempts;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    logic [7:0]  rx_q[$];
    int unsigned st_q[$];
    logic [63:0] last_word = '0;
    logic [63:0] target_pw = '0;
    logic        target_en = 1'b0;
    logic        led_force = 1'b0;

    assign led_g_n = !(led_force || (target_en && (last_word == target_pw)));

    pw_attempt_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .base_pw      (base_pw),
        .max_attempts (max_attempts),
        .led_g_n      (led_g_n),
        .tx           (tx),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .candidate    (candidate),
        .attempts     (attempts)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // UART decoder sampling mid-bit; records each frame's start-edge cycle.
    always begin : rx_mon
        logic [7:0]  b;
        int unsigned s;
        @(negedge tx);
        if (reset_n === 1'b1) begin
            s = cyc;
            repeat (BP / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BP) @(posedge clk);
                b[i] = tx;
            end
            repeat (BP) @(posedge clk);
            #1;
            rx_q.push_back(b);
            st_q.push_back(s);
            last_word = {b, last_word[63:8]};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start(input logic [63:0] pw, input logic [15:0] m);
        base_pw      = pw;
        max_attempts = m;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic wait_flag(input string tag, input bit want_exh, input int budget,
                             output int unsigned at);
        int n = 0;
        while (((want_exh ? exhausted : found) !== 1'b1) && (n < budget)) begin
            tick();
            n++;
        end
        at = cyc;
        check(tag, 64'(want_exh ? exhausted : found), 64'd1);
    endtask

    task automatic check_bytes(input string tag, input int idx, input logic [63:0] word);
        check({tag, "_count"}, 64'(rx_q.size() >= idx + 8), 64'd1);
        if (rx_q.size() >= idx + 8)
            for (int k = 0; k < 8; k++)
                check(tag, 64'(rx_q[idx + k]), 64'(word[8*k +: 8]));
    endtask

    initial begin : main
        int unsigned c0, t;
        int          r, n;
        logic [63:0] w;

        // Reset values
        ticks(3);
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_found", 64'(found), 64'd0);
        check("rst_exh", 64'(exhausted), 64'd0);
        check("rst_cand", candidate, 64'd0);
        check("rst_att", 64'(attempts), 64'd0);
        reset_n = 1'b1;
        ticks(2);

        // Single attempt, limit 1
        r = rx_q.size();
        w = 64'h293a216b33713234;
        pulse_start(w, 16'd1);
        c0 = cyc;
        check("t1_first_start_bit", 64'(tx), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        n = 0;
        while ((tx === 1'b0) && (n < 1000)) begin
            n++;
            tick();
        end
        check("t1_low_run_start_d0_d1", 64'(n), 64'd312);
        wait_flag("t1_exhausted", 1'b1, 20000, t);
        check("t1_exh_time", 64'(t - c0), 64'd10320);
        check("t1_attempts", 64'(attempts), 64'd1);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_tx_idle", 64'(tx), 64'd1);
        check("t1_cand", candidate, w);
        check_bytes("t1_bytes", r, w);
        if (st_q.size() >= r + 8) begin
            check("t1_stamp0", 64'(st_q[r] - c0), 64'd0);
            for (int i = 1; i < 8; i++)
                check("t1_frame_spacing", 64'(st_q[r+i] - st_q[r+i-1]), 64'd1040);
        end

        // Search until the target unlocks on 5
        r = rx_q.size();
        target_pw = 64'd5;
        target_en = 1'b1;
        pulse_start(64'd3, 16'd0);
        c0 = cyc;
        wait_flag("t2_found", 1'b0, 45000, t);
        check("t2_found_time", 64'(t - c0), 64'd31041);
        check("t2_cand", candidate, 64'd5);
        check("t2_attempts", 64'(attempts), 64'd3);
        check("t2_busy", 64'(busy), 64'd0);
        check("t2_exh", 64'(exhausted), 64'd0);
        check("t2_tx", 64'(tx), 64'd1);
        check_bytes("t2_bytes_att2", r + 8, 64'd4);
        if (st_q.size() >= r + 9)
            check("t2_attempt_spacing", 64'(st_q[r+8] - st_q[r+7]), 64'd4080);
        ticks(3);
        check("t2_found_held", 64'(found), 64'd1);
        target_en = 1'b0;

        // Wrap from all-ones, limit 2; LED low during SEND must be ignored
        r = rx_q.size();
        pulse_start(64'hFFFF_FFFF_FFFF_FFFF, 16'd2);
        c0 = cyc;
        check("t3_found_cleared", 64'(found), 64'd0);
        check("t3_att_cleared", 64'(attempts), 64'd0);
        ticks(200);
        led_force = 1'b1;
        ticks(20);
        led_force = 1'b0;
        wait_flag("t3_exhausted", 1'b1, 25000, t);
        check("t3_exh_time", 64'(t - c0), 64'd21680);
        check("t3_no_found", 64'(found), 64'd0);
        check("t3_attempts", 64'(attempts), 64'd2);
        check("t3_cand_wrap", candidate, 64'd0);
        check_bytes("t3_bytes_att1", r, 64'hFFFF_FFFF_FFFF_FFFF);
        check_bytes("t3_bytes_att2", r + 8, 64'd0);

        // Abort during bit 4 of frame 2
        w = 64'h1122334455667788;
        pulse_start(w, 16'd0);
        ticks(2529);
        check("t4_pre_abort_tx", 64'(tx), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_tx", 64'(tx), 64'd1);
        check("t4_abort_busy", 64'(busy), 64'd0);
        check("t4_abort_cand", candidate, w);
        check("t4_abort_att", 64'(attempts), 64'd0);
        base_pw = 64'h5555;
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        start   = 1'b0;
        abort   = 1'b0;
        check("t4_abort_wins_busy", 64'(busy), 64'd0);
        check("t4_abort_wins_cand", candidate, w);
        ticks(1100);
        check("t4_idle_tx", 64'(tx), 64'd1);
        r = rx_q.size();
        pulse_start(64'hA5C3_0F1E_2D3C_4B5A, 16'd0);
        check("t4_restart_cand", candidate, 64'hA5C3_0F1E_2D3C_4B5A);
        ticks(1100);
        check("t4_restart_count", 64'(rx_q.size() > r), 64'd1);
        if (rx_q.size() > r)
            check("t4_restart_byte0", 64'(rx_q[r]), 64'h5A);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Reset mid-frame, then a start during SEND is ignored
        pulse_start(64'hDEAD_BEEF_CAFE_F00D, 16'd0);
        ticks(20);
        check("t5_pre_reset_tx", 64'(tx), 64'd0);
        #2 reset_n = 1'b0;
        #1 check("t5_async_tx", 64'(tx), 64'd1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx !== 1'b1) n++;
        end
        check("t5_tx_high_in_reset", 64'(n), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_cand", candidate, 64'd0);
        check("t5_rst_att", 64'(attempts), 64'd0);
        reset_n = 1'b1;
        ticks(1200);
        r = rx_q.size();
        w = 64'h0123_4567_89AB_CDEF;
        pulse_start(w, 16'd0);
        c0 = cyc;
        ticks(300);
        base_pw = 64'hFFFF;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("t5_ignored_start_cand", candidate, w);
        check("t5_ignored_start_busy", 64'(busy), 64'd1);
        ticks(2100 - 301);
        check("t5_rx_count", 64'(rx_q.size() >= r + 2), 64'd1);
        if (rx_q.size() >= r + 2) begin
            check("t5_byte0", 64'(rx_q[r]), 64'hEF);
            check("t5_byte1", 64'(rx_q[r+1]), 64'hCD);
            check("t5_spacing", 64'(st_q[r+1] - st_q[r]), 64'd1040);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
